// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding scoreboard: default widths, entry layout
// and the hard-wired zero register.
package fwd_pkg;

    localparam int unsigned FWD_AW = 5;
    localparam int unsigned FWD_DW = 32;
    localparam int unsigned FWD_TW = 2;

    localparam logic [FWD_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic              valid;
        logic [FWD_AW-1:0] a3;
        logic [FWD_DW-1:0] wd;
        logic              wd_ok;
        logic [FWD_TW-1:0] tnew;
    } fwd_entry_t;

endpackage

// File: rtl/fwd_port_lookup.sv
// One decode read port: youngest-match priority search over the in-flight entries,
// yielding forwarded data, hit/pending flags and this port's stall term.
module fwd_port_lookup
    import fwd_pkg::*;
#(
    parameter int unsigned STAGES = 3,
    parameter int unsigned AW     = FWD_AW,
    parameter int unsigned DW     = FWD_DW,
    parameter int unsigned TW     = FWD_TW
) (
    input  logic [STAGES-1:0]    i_valid,
    input  logic [STAGES*AW-1:0] i_a3,
    input  logic [STAGES*DW-1:0] i_wd,
    input  logic [STAGES-1:0]    i_wd_ok,
    input  logic [STAGES*TW-1:0] i_tnew,
    input  logic [AW-1:0]        i_rd_addr,
    input  logic [TW-1:0]        i_rd_tuse,
    input  logic [DW-1:0]        i_rf_data,
    output logic                 o_hit,
    output logic                 o_pending,
    output logic                 o_stall,
    output logic [DW-1:0]        o_data
);

    logic          w_match;
    logic          w_ok;
    logic [DW-1:0] w_wd;
    logic [TW-1:0] w_tnew;

    always_comb begin
        w_match = 1'b0;
        w_ok    = 1'b0;
        w_wd    = '0;
        w_tnew  = '0;
        // Scan oldest to youngest so the lowest stage index overwrites older matches.
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (i_valid[k] && (i_a3[k*AW +: AW] == i_rd_addr) && (i_rd_addr != AW'(REG_ZERO))) begin
                w_match = 1'b1;
                w_ok    = i_wd_ok[k];
                w_wd    = i_wd[k*DW +: DW];
                w_tnew  = i_tnew[k*TW +: TW];
            end
        end
    end

    always_comb begin
        o_hit     = w_match && w_ok;
        o_pending = w_match && !w_ok;
        o_stall   = w_match && (w_tnew > i_rd_tuse);
        o_data    = o_hit ? w_wd : i_rf_data;
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: shifts issued register writes through the post-decode
// stages, captures late results, serves decode read ports and drives write-back.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int unsigned STAGES = 3,
    parameter int unsigned NREAD  = 2,
    parameter int unsigned DW     = FWD_DW,
    parameter int unsigned AW     = FWD_AW,
    parameter int unsigned TW     = $clog2(STAGES + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_a3,
    input  logic [TW-1:0]       issue_tnew,
    input  logic [DW-1:0]       issue_wd,
    input  logic                issue_wd_ok,
    input  logic [STAGES-1:0]   res_valid,
    input  logic [STAGES*DW-1:0] res_data,
    input  logic [NREAD*AW-1:0] rd_addr,
    input  logic [NREAD*TW-1:0] rd_tuse,
    input  logic [NREAD*DW-1:0] rf_data,
    output logic [NREAD*DW-1:0] fwd_data,
    output logic [NREAD-1:0]    fwd_hit,
    output logic [NREAD-1:0]    fwd_pending,
    output logic                stall,
    output logic                wb_en,
    output logic [AW-1:0]       wb_a3,
    output logic [DW-1:0]       wb_wd,
    output logic                err
);

    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_wd_ok;
    logic [AW-1:0]     r_a3   [STAGES];
    logic [DW-1:0]     r_wd   [STAGES];
    logic [TW-1:0]     r_tnew [STAGES];
    logic              r_err;

    logic [STAGES*AW-1:0] w_a3_flat;
    logic [STAGES*DW-1:0] w_wd_flat;
    logic [STAGES*TW-1:0] w_tnew_flat;
    logic [STAGES-2:0]    w_capture;
    logic [NREAD-1:0]     w_port_stall;
    logic                 w_issue_ok;
    logic                 w_unused_last_res;

    always_comb begin
        w_a3_flat   = '0;
        w_wd_flat   = '0;
        w_tnew_flat = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_a3_flat[k*AW +: AW]   = r_a3[k];
            w_wd_flat[k*DW +: DW]   = r_wd[k];
            w_tnew_flat[k*TW +: TW] = r_tnew[k];
        end
    end

    assign w_issue_ok = issue_valid && !stall && (issue_a3 != AW'(REG_ZERO));
    // Only the first result for a not-yet-ready entry is taken.
    assign w_capture  = r_valid[STAGES-2:0] & ~r_wd_ok[STAGES-2:0] & res_valid[STAGES-2:0];
    // The last stage has no successor to capture into.
    assign w_unused_last_res = ^{res_valid[STAGES-1], res_data[STAGES*DW-1 -: DW]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_wd_ok <= '0;
            r_err   <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                r_a3[k]   <= '0;
                r_wd[k]   <= '0;
                r_tnew[k] <= '0;
            end
        end else begin
            if (w_issue_ok) begin
                r_valid[0] <= 1'b1;
                r_a3[0]    <= issue_a3;
                r_wd[0]    <= issue_wd;
                r_wd_ok[0] <= issue_wd_ok;
                r_tnew[0]  <= issue_tnew;
            end else begin
                r_valid[0] <= 1'b0;
                r_a3[0]    <= '0;
                r_wd[0]    <= '0;
                r_wd_ok[0] <= 1'b0;
                r_tnew[0]  <= '0;
            end
            for (int k = 0; k < STAGES - 1; k++) begin
                r_valid[k+1] <= r_valid[k];
                r_a3[k+1]    <= r_a3[k];
                r_tnew[k+1]  <= (r_tnew[k] == '0) ? '0 : r_tnew[k] - TW'(1);
                if (w_capture[k]) begin
                    r_wd[k+1]    <= res_data[k*DW +: DW];
                    r_wd_ok[k+1] <= 1'b1;
                end else begin
                    r_wd[k+1]    <= r_wd[k];
                    r_wd_ok[k+1] <= r_wd_ok[k];
                end
            end
            if (r_valid[STAGES-1] && !r_wd_ok[STAGES-1]) begin
                r_err <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_port
        fwd_port_lookup #(
            .STAGES (STAGES),
            .AW     (AW),
            .DW     (DW),
            .TW     (TW)
        ) u_lookup (
            .i_valid   (r_valid),
            .i_a3      (w_a3_flat),
            .i_wd      (w_wd_flat),
            .i_wd_ok   (r_wd_ok),
            .i_tnew    (w_tnew_flat),
            .i_rd_addr (rd_addr[i*AW +: AW]),
            .i_rd_tuse (rd_tuse[i*TW +: TW]),
            .i_rf_data (rf_data[i*DW +: DW]),
            .o_hit     (fwd_hit[i]),
            .o_pending (fwd_pending[i]),
            .o_stall   (w_port_stall[i]),
            .o_data    (fwd_data[i*DW +: DW])
        );
    end

    assign stall = |w_port_stall;
    assign wb_en = r_valid[STAGES-1];
    assign wb_a3 = r_a3[STAGES-1];
    assign wb_wd = r_wd[STAGES-1];
    assign err   = r_err;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard at STAGES=3, NREAD=2 with hand-computed
// expectations for forwarding, stalls, capture, priority, write-back and error.
module tb_fwd_scoreboard;

    localparam int unsigned STAGES = 3;
    localparam int unsigned NREAD  = 2;
    localparam int unsigned DW     = 32;
    localparam int unsigned AW     = 5;
    localparam int unsigned TW     = 2;

    logic                  clk;
    logic                  reset;
    logic                  issue_valid;
    logic [AW-1:0]         issue_a3;
    logic [TW-1:0]         issue_tnew;
    logic [DW-1:0]         issue_wd;
    logic                  issue_wd_ok;
    logic [STAGES-1:0]     res_valid;
    logic [STAGES*DW-1:0]  res_data;
    logic [NREAD*AW-1:0]   rd_addr;
    logic [NREAD*TW-1:0]   rd_tuse;
    logic [NREAD*DW-1:0]   rf_data;
    logic [NREAD*DW-1:0]   fwd_data;
    logic [NREAD-1:0]      fwd_hit;
    logic [NREAD-1:0]      fwd_pending;
    logic                  stall;
    logic                  wb_en;
    logic [AW-1:0]         wb_a3;
    logic [DW-1:0]         wb_wd;
    logic                  err;

    int n_checks = 0;
    int n_pass   = 0;

    fwd_scoreboard #(
        .STAGES (STAGES),
        .NREAD  (NREAD),
        .DW     (DW),
        .AW     (AW),
        .TW     (TW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_a3    (issue_a3),
        .issue_tnew  (issue_tnew),
        .issue_wd    (issue_wd),
        .issue_wd_ok (issue_wd_ok),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .rd_addr     (rd_addr),
        .rd_tuse     (rd_tuse),
        .rf_data     (rf_data),
        .fwd_data    (fwd_data),
        .fwd_hit     (fwd_hit),
        .fwd_pending (fwd_pending),
        .stall       (stall),
        .wb_en       (wb_en),
        .wb_a3       (wb_a3),
        .wb_wd       (wb_wd),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        issue_a3    = '0;
        issue_tnew  = '0;
        issue_wd    = '0;
        issue_wd_ok = 1'b0;
        res_valid   = '0;
        res_data    = '0;
        rd_addr     = '0;
        rd_tuse     = '0;
        rf_data     = {32'hAAAA_0001, 32'hBBBB_0000};
    endtask

    task automatic issue(input logic [AW-1:0] a3, input logic [TW-1:0] tnew,
                         input logic [DW-1:0] wd, input logic ok);
        issue_valid = 1'b1;
        issue_a3    = a3;
        issue_tnew  = tnew;
        issue_wd    = wd;
        issue_wd_ok = ok;
    endtask

    task automatic no_nine(input string tag);
        check({tag, "_hit9"}, 32'(fwd_hit[1] | fwd_pending[1]), 32'd0);
        check({tag, "_wb9"}, 32'(wb_en && (wb_a3 == 5'd9)), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] rf0;
        logic [DW-1:0] rf1;

        // Reset with random inputs
        idle();
        reset       = 1'b1;
        issue_valid = 1'b1;
        issue_a3    = AW'($urandom_range(1, 31));
        issue_wd    = $urandom;
        issue_wd_ok = 1'b1;
        rf0         = $urandom;
        rf1         = $urandom;
        rf_data     = {rf1, rf0};
        rd_addr     = {issue_a3, issue_a3};
        res_valid   = '1;
        res_data    = {$urandom, $urandom, $urandom};
        cyc();
        cyc();
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_wb_en", 32'(wb_en), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_hit", 32'(fwd_hit), 32'd0);
        check("rst_pend", 32'(fwd_pending), 32'd0);
        check("rst_data0", fwd_data[31:0], rf0);
        check("rst_data1", fwd_data[63:32], rf1);
        reset = 1'b0;
        idle();
        cyc();

        // Immediate forward (jal-like)
        issue(5'd31, 2'd0, 32'h0000_3008, 1'b1);
        cyc();
        idle();
        rd_addr[4:0] = 5'd31;
        #1;
        check("jal_hit0", 32'(fwd_hit[0]), 32'd1);
        check("jal_data0", fwd_data[31:0], 32'h0000_3008);
        check("jal_stall", 32'(stall), 32'd0);
        cyc();
        check("jal_wb_early", 32'(wb_en), 32'd0);
        cyc();
        check("jal_wb_en", 32'(wb_en), 32'd1);
        check("jal_wb_a3", 32'(wb_a3), 32'd31);
        check("jal_wb_wd", wb_wd, 32'h0000_3008);
        cyc();

        // Load-use with a dropped issue during the stall
        idle();
        issue(5'd8, 2'd2, 32'h0, 1'b0);
        cyc();
        idle();
        rd_addr       = {5'd9, 5'd8};
        rd_tuse[1:0]  = 2'd1;
        issue(5'd9, 2'd0, 32'h0000_0099, 1'b1);
        #1;
        check("lu_stall1", 32'(stall), 32'd1);
        check("lu_pend1", 32'(fwd_pending[0]), 32'd1);
        cyc();
        issue_valid      = 1'b0;
        res_valid        = 3'b010;
        res_data[63:32]  = 32'hDEAD_BEEF;
        #1;
        check("lu_stall2", 32'(stall), 32'd0);
        check("lu_pend2", 32'(fwd_pending[0]), 32'd1);
        check("lu_nofwd_same_cycle", 32'(fwd_hit[0]), 32'd0);
        no_nine("drop_c2");
        cyc();
        res_valid = '0;
        res_data  = '0;
        #1;
        check("lu_hit3", 32'(fwd_hit[0]), 32'd1);
        check("lu_data3", fwd_data[31:0], 32'hDEAD_BEEF);
        check("lu_wb_en", 32'(wb_en), 32'd1);
        check("lu_wb_a3", 32'(wb_a3), 32'd8);
        check("lu_wb_wd", wb_wd, 32'hDEAD_BEEF);
        no_nine("drop_c3");
        cyc();
        no_nine("drop_c4");
        cyc();
        no_nine("drop_c5");
        check("lu_err", 32'(err), 32'd0);

        // Priority and $0
        idle();
        issue(5'd4, 2'd0, 32'h1, 1'b1);
        cyc();
        issue(5'd4, 2'd0, 32'h2, 1'b1);
        cyc();
        issue(5'd0, 2'd0, 32'h77, 1'b1);
        rd_addr[4:0] = 5'd4;
        #1;
        check("prio_data0", fwd_data[31:0], 32'h2);
        check("prio_hit0", 32'(fwd_hit[0]), 32'd1);
        cyc();
        idle();
        rd_addr      = {5'd0, 5'd4};
        rf_data      = {32'h5555_5555, 32'h1234_5678};
        #1;
        check("prio_data0_b", fwd_data[31:0], 32'h2);
        check("zero_hit1", 32'(fwd_hit[1] | fwd_pending[1]), 32'd0);
        check("zero_data1", fwd_data[63:32], 32'h5555_5555);
        cyc();
        cyc();
        cyc();

        // Sticky error
        idle();
        issue(5'd3, 2'd0, 32'h0, 1'b0);
        cyc();
        idle();
        cyc();
        cyc();
        check("err_wb_en", 32'(wb_en), 32'd1);
        check("err_n3", 32'(err), 32'd0);
        cyc();
        check("err_n4", 32'(err), 32'd1);
        cyc();
        cyc();
        check("err_sticky", 32'(err), 32'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        check("err_cleared", 32'(err), 32'd0);
        check("err_rst_wb", 32'(wb_en), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

- Parametrised forwarding scoreboard for the pipelined MIPS core.
- Each in-flight register-writing instruction is carried through `STAGES` post-decode stages as an entry holding destination, write data, data-ready flag and a Tnew countdown.
- Late results are captured stage by stage.
- Supports `NREAD` decode-stage read ports: per-port forwarded data, plus a global stall when a needed value cannot arrive by the consumer's Tuse.
- Drives register-file write-back from the last stage.

## Interface
Parameters:
- `STAGES`, 3: post-decode stages tracked (E, M, W by default); minimum 2.
- `NREAD`, 2: decode read ports.
- `DW`, 32: data width.
- `AW`, 5: register address width.
- `TW`, `$clog2(STAGES+1)`: Tnew/Tuse width.

Ports:
- `clk`  in  1  single clock; everything is on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `issue_valid`  in  1  decode issues a register-writing instruction this cycle.
- `issue_a3`  in  AW  destination register.
- `issue_tnew`  in  TW  cycles until the result sits in a stage register.
- `issue_wd`  in  DW  write data known at issue (e.g. PC+8).
- `issue_wd_ok`  in  1  `issue_wd` is final.
- `res_valid`  in  STAGES  bit k: stage k produced its result this cycle.
- `res_data`  in  STAGES*DW  slice k: stage-k result.
- `rd_addr`  in  NREAD*AW  read addresses.
- `rd_tuse`  in  NREAD*TW  per-port Tuse.
- `rf_data`  in  NREAD*DW  register-file read data.
- `fwd_data`  out  NREAD*DW  forwarded or register-file data.
- `fwd_hit`  out  NREAD  forwarded value is final.
- `fwd_pending`  out  NREAD  youngest match is not yet ready; consumer must re-forward later.
- `stall`  out  1  freeze fetch/decode.
- `wb_en`  out  1  write-back enable.
- `wb_a3`  out  AW  write-back register.
- `wb_wd`  out  DW  write-back data.
- `err`  out  1  sticky protocol error.

## Operation
**Entry state.** Entry k is a register with fields `valid`, `a3`, `wd`, `wd_ok`, `tnew`.

**Advance.** Entries advance every cycle; the pipeline never stops after decode.
- Stage 0 loads from the issue inputs when `issue_valid && !stall && issue_a3!=0`; otherwise it loads a bubble (`valid=0`).
- Entry k+1 loads entry k with `tnew` decremented, saturating at 0.
- If entry k is valid, `!wd_ok` and `res_valid[k]`, then entry k+1 gets `wd=res_data[k]` and `wd_ok=1`.
- `res_valid[k]` is ignored when entry k is invalid or already `wd_ok`; the first value wins.

**Lookup (combinational, per port i).**
- A port matches only when `rd_addr[i]!=0`; `a3==0` never matches.
- The match is the youngest valid entry (lowest k) with `a3==rd_addr[i]`. Older matches are shadowed.
- If the youngest match has `wd_ok`: `fwd_hit=1`, `fwd_data=wd`.
- If it is not ready: `fwd_pending=1`, `fwd_data=rf_data[i]`.
- No match: both flags 0, `fwd_data=rf_data[i]`.

**Stall.** `stall` = OR over ports of (match && `tnew > rd_tuse[i]`).

**Write-back.** `wb_en`, `wb_a3` and `wb_wd` show entry STAGES-1 directly: `wb_en = valid`.

**Error.** `err` sets on the edge after entry STAGES-1 is valid with `wd_ok=0`, and holds until `reset`.

## Timing
- **Reset:** every entry has `valid=0`, `wd_ok=0`, `tnew=0`, `a3=0`, `wd=0`; `err=0`. Consequently `stall=0`, `wb_en=0`, `wb_a3=0`, `wb_wd=0`, `fwd_hit=0`, `fwd_pending=0`, and `fwd_data=rf_data`.
- **Reset mid-operation:** all in-flight entries are discarded at that edge and `err` is cleared; reset beats issue.
- **Issue latency:** an issue accepted at edge N is visible to lookup in cycle N+1 at stage 0. It is at stage k in cycle N+1+k and on `wb_*` in cycle N+STAGES.
- **Stall vs. issue:** `stall` is derived only from entries and `rd_*`, never from `issue_*`. An issue in a stall cycle is dropped, and the decode stage re-presents it.
- **Result capture:** `res_data[k]` is never forwarded in the cycle it arrives; it is forwardable one edge later, from stage k+1.
- **Saturation:** `tnew` saturates at 0. An `issue_tnew` greater than STAGES-1 guarantees `err`.

## Structure
- **Shared package `fwd_pkg`:** `AW`/`DW` defaults, the entry struct (`valid`, `a3`, `wd`, `wd_ok`, `tnew`), and `REG_ZERO`.
- **Sub-module `fwd_port_lookup`:** one instance per read port. It is a priority match over the entry vector producing `hit`, `pending`, `data` and the per-port stall term.
- **Top level:** the entry shift chain, write-back, `err`, and the stall OR.

## Test plan
Defaults STAGES=3, NREAD=2.
- **Reset:** hold `reset` 2 cycles with random inputs → `stall=0`, `wb_en=0`, `err=0`, `fwd_hit=0`, `fwd_data=rf_data`.
- **Immediate forward (jal-like):** issue a3=31, wd=0x00003008, wd_ok=1, tnew=0. Next cycle `rd_addr0=31`, tuse=0 → `fwd_hit0=1`, `fwd_data0=0x00003008`, `stall=0`. Cycle N+3 → `wb_en=1`, `wb_a3=31`.
- **Load-use:** issue a3=8, tnew=2, wd_ok=0.
  - Cycle N+1, `rd_addr0=8`, tuse=1 → `stall=1`.
  - Cycle N+2 → `stall=0`, `fwd_pending0=1`; drive `res_valid[1]` with 0xDEADBEEF.
  - Cycle N+3 → `fwd_hit0=1`, `fwd_data0=0xDEADBEEF`, `wb_wd=0xDEADBEEF`.
- **Priority and $0:**
  - Issue a3=4 with wd=0x1, then a3=4 with wd=0x2; `rd_addr0=4` → `fwd_data0=0x2`.
  - Issue a3=0; `rd_addr1=0` → `fwd_hit1=0`, `fwd_data1=rf_data1`.
- **Dropped issue:** with stall forced by the load-use case, assert `issue_valid` a3=9 → no stage ever holds a3=9, and no `wb_en` for 9.
- **Error:** issue a3=3, tnew=0, wd_ok=0, with no `res_valid` → `err=1` at cycle N+4 and it stays 1 until `reset`.
